sample_stream_ctrl: RTL and testbench
=====================================

Name: sample_stream_ctrl

Overview:
- Sequences a synchronous sample memory (1-cycle read latency, HEX_WIDTH x HEX_DEPTH, preloaded from hex) into a framed pixel stream for camera-pipeline simulation and bring-up.
- Issues read addresses in raster order and inserts horizontal and vertical blanking.
- Tags each pixel with start-of-frame and end-of-line markers.
- Delivers pixels over a valid/ready interface with full backpressure.

Parameters:
- HEX_WIDTH, 24, sample/pixel width in bits
- H_ACTIVE, 8, pixels per line
- V_ACTIVE, 8, lines per frame; HEX_DEPTH = H_ACTIVE*V_ACTIVE (package constant)
- H_BLANK, 4, idle cycles after each non-final line, must be >= 1
- V_BLANK, 16, idle cycles after each frame, must be >= 1

Ports:
- clk_in  in  1  sole clock
- rst_n_in  in  1  reset; one clock, reset is asynchronous and active-low
- start_in  in  1  pulse; begins streaming when IDLE
- stop_in  in  1  pulse; finish current frame, then IDLE
- rd_en_out  out  1  memory read strobe
- addr_out  out  $clog2(HEX_DEPTH)  memory read address
- rd_data_in  in  HEX_WIDTH  memory data, valid 1 cycle after rd_en_out
- data_out  out  HEX_WIDTH  pixel
- valid_out  out  1  pixel valid
- ready_in  in  1  downstream accept
- sof_out  out  1  qualifies data_out: first pixel of frame
- eol_out  out  1  qualifies data_out: last pixel of line
- frame_done_out  out  1  1-cycle pulse when the last frame pixel is accepted
- busy_out  out  1  high whenever state != IDLE or the buffer is non-empty

Behaviour:
- Reset (async assert, sync release): state IDLE, col/row/addr/blank counters 0. Outputs rd_en_out, valid_out, sof_out, eol_out, frame_done_out, busy_out and stop_pending are all 0. data_out is 0.
- States:
  - IDLE -> ACTIVE on start_in.
  - ACTIVE: one fetch per cycle while credit is available.
  - After the last column is fetched: non-final line -> HBLANK; final line -> VBLANK.
  - HBLANK: H_BLANK cycles, then ACTIVE with row+1, col 0.
  - VBLANK: V_BLANK cycles, then IDLE if stop_pending, else ACTIVE with row 0, addr 0.
- Credit rule: fetch only when buffer occupancy + in-flight reads < 2. This guarantees no overflow under any ready_in pattern.
- Address: addr_out = linear counter, increments per fetch, wraps to 0 at HEX_DEPTH (end of frame). Never out of range.
- Tags: sof/eol are computed at fetch time, delayed 1 cycle alongside the read, and written into the 2-entry buffer with the data.
- Output:
  - Buffer head drives data_out/sof_out/eol_out/valid_out.
  - A transfer occurs on valid_out & ready_in.
  - data_out must stay stable while valid_out & !ready_in.
- Throughput: with ready_in held high, 1 pixel/cycle during ACTIVE. First valid_out appears 2 cycles after the start_in cycle.
- Blanking is counted from fetch, not acceptance. Backpressure stretches effective blanking but never shortens a line.
- stop_in:
  - stop_in in any non-IDLE state sets stop_pending; it clears on entering IDLE.
  - stop_in in IDLE is ignored.
  - start_in while non-IDLE is ignored.
  - start_in and stop_in together in IDLE: start wins, stop is ignored.
- frame_done_out pulses on acceptance of the pixel with row=V_ACTIVE-1, col=H_ACTIVE-1, independent of state.
- Reset mid-frame: immediate return to IDLE. Buffer and in-flight reads are discarded, and no partial pixel is presented after release.

Optional Feature:
- SAMPLE_STREAM_PATTERN_EN
- When defined:
  - Adds input pattern_sel_in (1 bit).
  - When pattern_sel_in is high, memory is not read: rd_en_out stays 0.
  - The enqueued data is {row, col}, zero-extended to HEX_WIDTH. Timing, tags and the credit rule are unchanged.
  - pattern_sel_in is sampled only at frame start; a change takes effect at the next frame.
- When undefined: no extra port; the data source is always rd_data_in.

Decomposition:
- Package sample_stream_pkg:
  - state enum (IDLE, ACTIVE, HBLANK, VBLANK)
  - HEX_DEPTH derivation function
  - packed pixel struct {data, sof, eol}
- Sub-module: stream_skid_buf, a 2-entry valid/ready buffer of the pixel struct with an occupancy output used for credit.

Test Plan:
All scenarios use H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, V_BLANK=3, and memory word i = i.
- start_in pulse, ready_in=1 -> data 0,1,2,3, 2 idle cycles, 4,5,6,7. sof on 0; eol on 3 and 7; frame_done on 7; addresses 0..7 then 0 again.
- ready_in toggled 1010... -> same 8-value sequence, none dropped or duplicated. data_out stable during stalls; rd_en_out never creates more than 2 outstanding entries.
- stop_in mid line 0 -> frame completes with values 4..7. After V_BLANK, IDLE and busy_out=0; no further rd_en_out.
- rst_n_in low during pixel 5 -> valid_out=0 immediately. After release plus start_in, the stream restarts at 0 with sof.
- start_in while ACTIVE, and start_in+stop_in in IDLE -> first ignored; second starts streaming, runs continuously, and does not stop.
- SAMPLE_STREAM_PATTERN_EN, pattern_sel_in=1 -> values {0,0},{0,1},{0,2},{0,3},{1,0}..{1,3}. rd_en_out stays 0; tags and frame_done as in the first scenario.

Source files
------------

// File: rtl/sample_stream_pkg.sv
// Shared types and constants for the sample stream controller:
// FSM states, frame-size derivation and the buffered pixel record.
package sample_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_e;

  localparam int PIX_W = 24;

  function automatic int hex_depth(input int h_active, input int v_active);
    return h_active * v_active;
  endfunction

  localparam int HEX_DEPTH = hex_depth(8, 8);

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sof;
    logic             eol;
  } pixel_t;

endpackage

// File: rtl/sample_stream_ctrl_skid_buf.sv
// Two-entry valid/ready buffer for tagged pixels; the head entry drives the
// outputs directly, and occupancy feeds the fetch credit check upstream.
module stream_skid_buf
  import sample_stream_pkg::*;
#(
  parameter type T = pixel_t
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       in_valid,
  input  T           in_data,
  output T           out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] occupancy
);

  T           e0_q, e0_d;
  T           e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pop_s;

  assign pop_s = (cnt_q != 2'd0) && out_ready;

  // Entry/count update; upstream credit guarantees no push into a full, stalled buffer.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (in_valid) begin
          e0_d  = in_data;
          cnt_d = 2'd1;
        end else begin
          cnt_d = 2'd0;
        end
      end
      2'd1: begin
        if (in_valid && pop_s) begin
          e0_d = in_data;
        end else if (in_valid) begin
          e1_d  = in_data;
          cnt_d = 2'd2;
        end else if (pop_s) begin
          cnt_d = 2'd0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      2'd2: begin
        if (pop_s) begin
          e0_d = e1_q;
          if (in_valid) begin
            e1_d = in_data;
          end else begin
            cnt_d = 2'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  // Buffer storage.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_data  = e0_q;
  assign out_valid = (cnt_q != 2'd0);
  assign occupancy = cnt_q;

endmodule

// File: rtl/sample_stream_ctrl.sv
// Raster-order sample memory sequencer producing a framed valid/ready pixel stream.
// Optional SAMPLE_STREAM_PATTERN_EN replaces memory data with a {row, col} test pattern.
module sample_stream_ctrl
  import sample_stream_pkg::*;
#(
  parameter  int HEX_WIDTH = PIX_W,
  parameter  int H_ACTIVE  = 8,
  parameter  int V_ACTIVE  = 8,
  parameter  int H_BLANK   = 4,
  parameter  int V_BLANK   = 16,
  localparam int DEPTH     = hex_depth(H_ACTIVE, V_ACTIVE),
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  input  logic                 stop_in,
  output logic                 rd_en_out,
  output logic [AW-1:0]        addr_out,
  input  logic [HEX_WIDTH-1:0] rd_data_in,
  output logic [HEX_WIDTH-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 sof_out,
  output logic                 eol_out,
  output logic                 frame_done_out,
  output logic                 busy_out
`ifdef SAMPLE_STREAM_PATTERN_EN
  ,
  input  logic                 pattern_sel_in
`endif
);

  localparam int CW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int RW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  typedef struct packed {
    logic [HEX_WIDTH-1:0] data;
    logic                 sof;
    logic                 eol;
  } pix_t;

  state_e               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [RW-1:0]        out_row_q, out_row_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [BW-1:0]        blank_q, blank_d;
  logic                 stop_pending_q, stop_pending_d;
  logic                 inflight_q, inflight_d;
  logic                 tag_sof_q, tag_sof_d;
  logic                 tag_eol_q, tag_eol_d;
  logic [1:0]           occ_s;
  logic                 pop_s, credit_s, fetch_s, pattern_now_s;
  logic [HEX_WIDTH-1:0] fill_data_s;
  pix_t                 push_pix_s, head_s;

  assign pop_s    = valid_out & ready_in;
  // Credit counts occupancy after this cycle's transfer so a full-rate stream never stalls.
  assign credit_s = (({1'b0, occ_s} + {2'b00, inflight_q}) - {2'b00, pop_s}) < 3'd2;
  assign fetch_s  = credit_s && ((state_q == ACTIVE) || ((state_q == IDLE) && start_in));

  // Raster sequencing, blanking and stop handling.
  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    addr_d         = addr_q;
    blank_d        = blank_q;
    stop_pending_d = stop_pending_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: state_d = ACTIVE;
      HBLANK: begin
        if (blank_q == BW'(H_BLANK - 1)) begin
          state_d = ACTIVE;
          row_d   = row_q + RW'(1);
          blank_d = '0;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      VBLANK: begin
        if (blank_q == BW'(V_BLANK - 1)) begin
          blank_d = '0;
          state_d = (stop_pending_q || stop_in) ? IDLE : ACTIVE;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (fetch_s) begin
      addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
      if (col_q == CW'(H_ACTIVE - 1)) begin
        col_d   = '0;
        blank_d = '0;
        if (row_q == RW'(V_ACTIVE - 1)) begin
          row_d   = '0;
          state_d = VBLANK;
        end else begin
          state_d = HBLANK;
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      addr_d = addr_q;
    end

    if (state_d == IDLE) begin
      stop_pending_d = 1'b0;
    end else if (stop_in && (state_q != IDLE)) begin
      stop_pending_d = 1'b1;
    end else begin
      stop_pending_d = stop_pending_q;
    end
  end

  // Tags travel one cycle alongside the memory read; output row tracks frame_done.
  always_comb begin
    inflight_d = fetch_s;
    tag_sof_d  = (row_q == '0) && (col_q == '0);
    tag_eol_d  = (col_q == CW'(H_ACTIVE - 1));
    if (pop_s && eol_out) begin
      out_row_d = (out_row_q == RW'(V_ACTIVE - 1)) ? '0 : out_row_q + RW'(1);
    end else begin
      out_row_d = out_row_q;
    end
  end

  // Control state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= IDLE;
      col_q          <= '0;
      row_q          <= '0;
      out_row_q      <= '0;
      addr_q         <= '0;
      blank_q        <= '0;
      stop_pending_q <= 1'b0;
      inflight_q     <= 1'b0;
      tag_sof_q      <= 1'b0;
      tag_eol_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      out_row_q      <= out_row_d;
      addr_q         <= addr_d;
      blank_q        <= blank_d;
      stop_pending_q <= stop_pending_d;
      inflight_q     <= inflight_d;
      tag_sof_q      <= tag_sof_d;
      tag_eol_q      <= tag_eol_d;
    end
  end

`ifdef SAMPLE_STREAM_PATTERN_EN
  logic          pattern_q, pattern_d;
  logic          pat_use_q, pat_use_d;
  logic [RW-1:0] pat_row_q, pat_row_d;
  logic [CW-1:0] pat_col_q, pat_col_d;

  // Pattern select is latched only when a frame begins.
  always_comb begin
    pattern_now_s = (state_q == IDLE) ? pattern_sel_in : pattern_q;
    if (((state_q == IDLE) && start_in) || ((state_q == VBLANK) && (state_d == ACTIVE))) begin
      pattern_d = pattern_sel_in;
    end else begin
      pattern_d = pattern_q;
    end
    pat_use_d   = pattern_now_s;
    pat_row_d   = row_q;
    pat_col_d   = col_q;
    fill_data_s = pat_use_q ? HEX_WIDTH'({pat_row_q, pat_col_q}) : rd_data_in;
  end

  // Pattern pipeline.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pattern_q <= 1'b0;
      pat_use_q <= 1'b0;
      pat_row_q <= '0;
      pat_col_q <= '0;
    end else begin
      pattern_q <= pattern_d;
      pat_use_q <= pat_use_d;
      pat_row_q <= pat_row_d;
      pat_col_q <= pat_col_d;
    end
  end
`else
  assign pattern_now_s = 1'b0;
  assign fill_data_s   = rd_data_in;
`endif

  assign push_pix_s = {fill_data_s, tag_sof_q, tag_eol_q};

  stream_skid_buf #(
    .T(pix_t)
  ) u_buf (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .in_valid  (inflight_q),
    .in_data   (push_pix_s),
    .out_data  (head_s),
    .out_valid (valid_out),
    .out_ready (ready_in),
    .occupancy (occ_s)
  );

  assign rd_en_out      = fetch_s & ~pattern_now_s;
  assign addr_out       = addr_q;
  assign data_out       = head_s.data;
  assign sof_out        = head_s.sof;
  assign eol_out        = head_s.eol;
  assign frame_done_out = pop_s & eol_out & (out_row_q == RW'(V_ACTIVE - 1));
  assign busy_out       = (state_q != IDLE) || (occ_s != 2'd0);

endmodule

// File: tb/tb_sample_stream_ctrl.sv
// Directed bench for sample_stream_ctrl with a 4x2 frame, H_BLANK=2, V_BLANK=3
// and a memory whose word i holds i.
module tb_sample_stream_ctrl;

  typedef struct packed {
    logic        valid;
    logic [23:0] data;
    logic        sof;
    logic        eol;
    logic        fd;
    logic        rd_en;
    logic [2:0]  addr;
    logic        busy;
  } obs_t;

  typedef struct {
    logic rst;
    logic start;
    logic stop;
    logic ready;
    logic pat;
    obs_t exp;
  } vec_t;

  logic        clk, rst_n, start, stop, ready;
  logic        rd_en, valid, sof, eol, fd, busy;
  logic [2:0]  addr;
  logic [23:0] rd_data, data;
`ifdef SAMPLE_STREAM_PATTERN_EN
  logic        pat_sel;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  sample_stream_ctrl #(
    .HEX_WIDTH(24), .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(2), .V_BLANK(3)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .start_in       (start),
    .stop_in        (stop),
    .rd_en_out      (rd_en),
    .addr_out       (addr),
    .rd_data_in     (rd_data),
    .data_out       (data),
    .valid_out      (valid),
    .ready_in       (ready),
    .sof_out        (sof),
    .eol_out        (eol),
    .frame_done_out (fd),
    .busy_out       (busy)
`ifdef SAMPLE_STREAM_PATTERN_EN
    ,
    .pattern_sel_in (pat_sel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word i = i, one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= 24'(addr);
  end

  // Expected outputs k cycles after a start pulse with ready held high (hand-derived).
  function automatic obs_t canon(input int k);
    obs_t o;
    int addr_tab [17] = '{0, 1, 2, 3, 4, 4, 4, 5, 6, 7, 0, 0, 0, 0, 1, 2, 3};
    int data_tab [17] = '{-1, -1, 0, 1, 2, 3, -1, -1, 4, 5, 6, 7, -1, -1, -1, 0, 1};
    o       = '0;
    o.busy  = (k != 0);
    o.rd_en = (k <= 3) || (k >= 6 && k <= 9) || (k >= 13);
    o.addr  = 3'(addr_tab[k]);
    o.valid = (data_tab[k] >= 0);
    o.data  = (data_tab[k] >= 0) ? 24'(data_tab[k]) : 24'd0;
    o.sof   = (k == 2) || (k == 15);
    o.eol   = (k == 5) || (k == 11);
    o.fd    = (k == 11);
    return o;
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic p,
                              input logic rd, input logic pt, input obs_t e);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.ready = rd; v.pat = pt; v.exp = e;
    return v;
  endfunction

  function automatic obs_t observe(input logic in_rst);
    obs_t o;
    o.valid = valid;
    o.data  = (valid || in_rst) ? data : 24'd0;
    o.sof   = sof & valid;
    o.eol   = eol & valid;
    o.fd    = fd;
    o.rd_en = rd_en;
    o.addr  = addr;
    o.busy  = busy;
    return o;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  vec_t tbl[$];

  initial begin
    obs_t got, e;
    int   idx, issued, acc;
    logic stall_prev;
    logic [23:0] prev_data;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b1;
`ifdef SAMPLE_STREAM_PATTERN_EN
    pat_sel = 1'b0;
`endif

    // A: reset state, then a plain start with ready high.
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, obs_t'('0)));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, obs_t'('0)));
    for (int k = 0; k < 17; k++) tbl.push_back(mk(1'b0, k == 0, 1'b0, 1'b1, 1'b0, canon(k)));
    // B: stop during line 0; frame completes, then idle.
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, obs_t'('0)));
    for (int k = 0; k < 17; k++)
      tbl.push_back(mk(1'b0, k == 0, k == 1, 1'b1, 1'b0, (k >= 13) ? obs_t'('0) : canon(k)));
    // C: start+stop together in IDLE, then a stray start while ACTIVE.
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, obs_t'('0)));
    for (int k = 0; k < 17; k++)
      tbl.push_back(mk(1'b0, (k == 0) || (k == 3), k == 0, 1'b1, 1'b0, canon(k)));
    // D: reset while pixel 5 is presented, then restart.
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, obs_t'('0)));
    for (int k = 0; k < 9; k++) tbl.push_back(mk(1'b0, k == 0, 1'b0, 1'b1, 1'b0, canon(k)));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, obs_t'('0)));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1'b0, k == 0, 1'b0, 1'b1, 1'b0, canon(k)));
`ifdef SAMPLE_STREAM_PATTERN_EN
    // E: pattern source; {row,col} equals the linear index for this geometry.
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, obs_t'('0)));
    for (int k = 0; k < 17; k++) begin
      e = canon(k);
      e.rd_en = 1'b0;
      tbl.push_back(mk(1'b0, k == 0, 1'b0, 1'b1, 1'b1, e));
    end
`endif

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      rst_n = ~tbl[i].rst;
      start = tbl[i].start;
      stop  = tbl[i].stop;
      ready = tbl[i].ready;
`ifdef SAMPLE_STREAM_PATTERN_EN
      pat_sel = tbl[i].pat;
`endif
      @(negedge clk);
      got = observe(tbl[i].rst);
      n_cmp++;
      if (got !== tbl[i].exp) begin
        n_fail++;
        $display("FAIL vec%0d: got v=%b d=%0d sof=%b eol=%b fd=%b rd=%b a=%0d busy=%b required v=%b d=%0d sof=%b eol=%b fd=%b rd=%b a=%0d busy=%b",
                 i, got.valid, got.data, got.sof, got.eol, got.fd, got.rd_en, got.addr, got.busy,
                 tbl[i].exp.valid, tbl[i].exp.data, tbl[i].exp.sof, tbl[i].exp.eol,
                 tbl[i].exp.fd, tbl[i].exp.rd_en, tbl[i].exp.addr, tbl[i].exp.busy);
      end
      @(posedge clk); #1;
    end

    // Backpressure: ready toggles 1010...; order, stability and credit bound.
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b1;
`ifdef SAMPLE_STREAM_PATTERN_EN
    pat_sel = 1'b0;
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    idx = 0; issued = 0; acc = 0; stall_prev = 1'b0; prev_data = 24'd0;
    for (int c = 0; c < 80 && idx < 8; c++) begin
      start = (c == 0);
      ready = ((c % 2) == 0);
      @(negedge clk);
      if (rd_en) issued++;
      if (stall_prev) check("stall_hold", {valid, data}, {1'b1, prev_data});
      if (valid && ready) begin
        check("bp_data", data, idx);
        check("bp_tags", {sof, eol, fd}, {idx == 0, (idx == 3) || (idx == 7), idx == 7});
        idx++;
        acc++;
      end
      check("bp_outstanding_le2", (issued - acc) <= 2, 1);
      stall_prev = valid && !ready;
      prev_data  = data;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("bp_pixel_count", idx, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
